// File: rtl/rs_load.sv
// In-order load reservation station feeding fu_mem: circular buffer, CDB wakeup, head-only issue, ROB-window flush.
// Optional RS_LOAD_WAKEUP_BYPASS_EN lets a same-cycle CDB hit on the head operand issue immediately.
package rs_load_pkg;
    localparam int RS_ROB_W = 5;

    typedef struct packed {
        logic [6:0]          opcode;
        logic [4:0]          rd;
        logic [2:0]          func3;
        logic [11:0]         imm;
        logic [RS_ROB_W-1:0] rob_index;
    } rs_data_t;
endpackage

module rs_load
    import rs_load_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ROB_W  = RS_ROB_W,
    parameter int PREG_W = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dispatch_valid,
    input  rs_data_t          dispatch_data,
    input  logic [PREG_W-1:0] dispatch_ps1,
    input  logic              dispatch_ps1_rdy,
    input  logic              cdb_valid,
    input  logic [PREG_W-1:0] cdb_tag,
    input  logic              fu_mem_ready,
    input  logic              mispredict,
    input  logic [ROB_W-1:0]  mispredict_tag,
    input  logic [ROB_W-1:0]  curr_rob_tag,
    output logic              rs_full,
    output logic              issued,
    output rs_data_t          data_out,
    output logic [PREG_W-1:0] issue_ps1
);
    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    // Tag t is wrong-path iff it lies strictly after the branch and before the ROB tail.
    function automatic logic in_window(input logic [ROB_W-1:0] t,
                                       input logic [ROB_W-1:0] br,
                                       input logic [ROB_W-1:0] tail);
        logic [ROB_W-1:0] d;
        logic [ROB_W-1:0] lim;
        d   = t - br;
        lim = tail - br;
        return (d != '0) && (d < lim);
    endfunction

    logic [PW-1:0]     head_q, head_d, tail_q, tail_d, count;
    logic [IW-1:0]     hidx, tidx, scan_idx;
    rs_data_t          data_q [DEPTH];
    logic [PREG_W-1:0] ps1_q  [DEPTH];
    logic [DEPTH-1:0]  rdy_q;
    logic [DEPTH-1:0]  flush_hit;
    logic              empty, full, head_rdy, issue_go, disp_go, fl_found;
    logic [PW-1:0]     fl_off;
    logic              issued_q;
    rs_data_t          data_out_q;
    logic [PREG_W-1:0] issue_ps1_q;

    assign count = tail_q - head_q;
    assign empty = (count == '0);
    assign full  = (count == PW'(DEPTH));
    assign hidx  = head_q[IW-1:0];
    assign tidx  = tail_q[IW-1:0];

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        logic [IW-1:0] off;
        assign off          = IW'(g) - hidx;
        assign flush_hit[g] = mispredict && ({1'b0, off} < count)
                              && in_window(data_q[g].rob_index, mispredict_tag, curr_rob_tag);
    end

    // Flushed loads form the youngest suffix; find the oldest one relative to head.
    always_comb begin
        fl_found = 1'b0;
        fl_off   = '0;
        scan_idx = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            scan_idx = hidx + IW'(k);
            if (flush_hit[scan_idx]) begin
                fl_found = 1'b1;
                fl_off   = PW'(k);
            end
        end
    end

`ifdef RS_LOAD_WAKEUP_BYPASS_EN
    assign head_rdy = rdy_q[hidx] | (cdb_valid && (cdb_tag == ps1_q[hidx]));
`else
    assign head_rdy = rdy_q[hidx];
`endif

    assign issue_go = !empty && head_rdy && fu_mem_ready && !flush_hit[hidx];
    assign disp_go  = dispatch_valid && !full && !mispredict;

    always_comb begin
        head_d = issue_go ? head_q + PW'(1) : head_q;
        tail_d = tail_q;
        if (fl_found)
            tail_d = head_q + fl_off;
        else if (disp_go)
            tail_d = tail_q + PW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q      <= '0;
            tail_q      <= '0;
            rdy_q       <= '0;
            issued_q    <= 1'b0;
            data_out_q  <= '0;
            issue_ps1_q <= '0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            issued_q <= issue_go;
            if (issue_go) begin
                data_out_q  <= data_q[hidx];
                issue_ps1_q <= ps1_q[hidx];
            end
            for (int i = 0; i < DEPTH; i++)
                if (cdb_valid && ps1_q[i] == cdb_tag)
                    rdy_q[i] <= 1'b1;
            // A new entry overrides any stale wakeup on the reused slot.
            if (disp_go)
                rdy_q[tidx] <= dispatch_ps1_rdy | (cdb_valid && cdb_tag == dispatch_ps1);
        end
    end

    // Payload storage needs no reset: liveness comes from the pointers.
    always_ff @(posedge clk) begin
        if (disp_go) begin
            data_q[tidx] <= dispatch_data;
            ps1_q[tidx]  <= dispatch_ps1;
        end
    end

    assign rs_full   = full;
    assign issued    = issued_q;
    assign data_out  = data_out_q;
    assign issue_ps1 = issue_ps1_q;
endmodule

// File: tb/tb_rs_load.sv
// Directed self-checking bench for rs_load: issue latency, wakeup, full, flush, stall and reset.
module tb_rs_load;
    import rs_load_pkg::*;

    logic       clk = 1'b0;
    logic       reset, dispatch_valid, dispatch_ps1_rdy, cdb_valid, fu_mem_ready, mispredict;
    rs_data_t   dispatch_data;
    logic [6:0] dispatch_ps1, cdb_tag, issue_ps1;
    logic [4:0] mispredict_tag, curr_rob_tag;
    logic       rs_full, issued;
    rs_data_t   data_out;
    int         checks = 0;
    int         errors = 0;

    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;

    rs_load dut (
        .clk(clk), .reset(reset), .dispatch_valid(dispatch_valid), .dispatch_data(dispatch_data),
        .dispatch_ps1(dispatch_ps1), .dispatch_ps1_rdy(dispatch_ps1_rdy), .cdb_valid(cdb_valid),
        .cdb_tag(cdb_tag), .fu_mem_ready(fu_mem_ready), .mispredict(mispredict),
        .mispredict_tag(mispredict_tag), .curr_rob_tag(curr_rob_tag), .rs_full(rs_full),
        .issued(issued), .data_out(data_out), .issue_ps1(issue_ps1)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic rs_data_t mk(input logic [2:0] f3, input logic [4:0] rob);
        rs_data_t d;
        d           = '0;
        d.opcode    = 7'b0000011;
        d.func3     = f3;
        d.imm       = {7'd0, rob};
        d.rob_index = rob;
        return d;
    endfunction

    task automatic disp(input logic [4:0] rob, input logic [2:0] f3, input logic [6:0] ps1, input logic rdy);
        dispatch_valid   = 1'b1;
        dispatch_data    = mk(f3, rob);
        dispatch_ps1     = ps1;
        dispatch_ps1_rdy = rdy;
        cyc();
        dispatch_valid   = 1'b0;
    endtask

    task automatic wake(input logic [6:0] tag);
        cdb_valid = 1'b1;
        cdb_tag   = tag;
        cyc();
        cdb_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) cyc();
        reset = 1'b0;
        checks++;
        if (rs_full !== 1'b0 || issued !== 1'b0 || data_out !== '0 || issue_ps1 !== '0) begin
            errors++;
            $display("FAIL reset_state: full=%b issued=%b data=%h ps1=%0d, required 0/0/0/0",
                     rs_full, issued, data_out, issue_ps1);
        end
    endtask

    task automatic test_basic_issue();
        fu_mem_ready = 1'b1;
        disp(5'd1, LW, 7'd5, 1'b1);
        checks++;
        if (issued !== 1'b0) begin errors++; $display("FAIL lw_not_early: issued=%b required 0", issued); end
        cyc();
        checks++;
        if (issued !== 1'b1 || data_out.rob_index !== 5'd1 || data_out.func3 !== LW || issue_ps1 !== 7'd5) begin
            errors++;
            $display("FAIL lw_issue: issued=%b rob=%0d f3=%b ps1=%0d, required 1/1/010/5",
                     issued, data_out.rob_index, data_out.func3, issue_ps1);
        end
        cyc();
        checks++;
        if (issued !== 1'b0 || rs_full !== 1'b0 || data_out.rob_index !== 5'd1) begin
            errors++;
            $display("FAIL lw_after: issued=%b full=%b held_rob=%0d, required 0/0/1", issued, rs_full, data_out.rob_index);
        end
    endtask

    task automatic test_wakeup();
        disp(5'd2, LBU, 7'd9, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            checks++;
            if (issued !== 1'b0) begin errors++; $display("FAIL wait_%0d: issued=%b required 0", i, issued); end
        end
        wake(7'd9);
`ifndef RS_LOAD_WAKEUP_BYPASS_EN
        checks++;
        if (issued !== 1'b0) begin errors++; $display("FAIL wake_lat: issued=%b required 0", issued); end
        cyc();
`endif
        checks++;
        if (issued !== 1'b1 || data_out.rob_index !== 5'd2 || data_out.func3 !== LBU || issue_ps1 !== 7'd9) begin
            errors++;
            $display("FAIL wake_issue: issued=%b rob=%0d f3=%b ps1=%0d, required 1/2/100/9",
                     issued, data_out.rob_index, data_out.func3, issue_ps1);
        end
        cyc();
    endtask

    task automatic test_full();
        for (int i = 0; i < 8; i++) disp(5'(10 + i), LW, 7'(20 + i), 1'b0);
        checks++;
        if (rs_full !== 1'b1) begin errors++; $display("FAIL full_set: rs_full=%b required 1", rs_full); end
        disp(5'd30, LW, 7'd60, 1'b1);
        checks++;
        if (rs_full !== 1'b1 || issued !== 1'b0) begin
            errors++; $display("FAIL full_drop: full=%b issued=%b required 1/0", rs_full, issued);
        end
        fu_mem_ready = 1'b0;
        for (int i = 0; i < 8; i++) wake(7'(20 + i));
        fu_mem_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc();
            checks++;
            if (issued !== 1'b1 || data_out.rob_index !== 5'(10 + i)) begin
                errors++;
                $display("FAIL drain_%0d: issued=%b rob=%0d, required 1/%0d", i, issued, data_out.rob_index, 10 + i);
            end
        end
        cyc();
        checks++;
        if (issued !== 1'b0 || rs_full !== 1'b0) begin
            errors++; $display("FAIL drain_end: issued=%b full=%b required 0/0", issued, rs_full);
        end
    endtask

    task automatic test_flush_window();
        logic [4:0] exp_rob [8];
        exp_rob = '{5'd2, 5'd4, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd12};
        disp(5'd2, LW, 7'd40, 1'b0);
        disp(5'd4, LW, 7'd41, 1'b0);
        disp(5'd5, LW, 7'd42, 1'b0);
        disp(5'd6, LW, 7'd43, 1'b0);
        mispredict = 1'b1; mispredict_tag = 5'd3; curr_rob_tag = 5'd8;
        cyc();
        mispredict = 1'b0;
        checks++;
        if (rs_full !== 1'b0 || issued !== 1'b0) begin
            errors++; $display("FAIL flush_state: full=%b issued=%b required 0/0", rs_full, issued);
        end
        disp(5'd4, LW, 7'd44, 1'b0);
        for (int i = 0; i < 5; i++) disp(5'(7 + i), LW, 7'(45 + i), 1'b0);
        checks++;
        if (rs_full !== 1'b0) begin errors++; $display("FAIL flush_count7: rs_full=%b required 0", rs_full); end
        disp(5'd12, LW, 7'd50, 1'b0);
        checks++;
        if (rs_full !== 1'b1) begin errors++; $display("FAIL flush_count8: rs_full=%b required 1", rs_full); end
        fu_mem_ready = 1'b0;
        wake(7'd40);
        for (int i = 44; i <= 50; i++) wake(7'(i));
        fu_mem_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc();
            checks++;
            if (issued !== 1'b1 || data_out.rob_index !== exp_rob[i]) begin
                errors++;
                $display("FAIL flush_order_%0d: issued=%b rob=%0d, required 1/%0d", i, issued, data_out.rob_index, exp_rob[i]);
            end
        end
        cyc();
        checks++;
        if (issued !== 1'b0) begin errors++; $display("FAIL flush_drained: issued=%b required 0", issued); end
    endtask

    task automatic test_flush_head();
        fu_mem_ready = 1'b0;
        disp(5'd5, LW, 7'd12, 1'b1);
        mispredict = 1'b1; mispredict_tag = 5'd4; curr_rob_tag = 5'd10; fu_mem_ready = 1'b1;
        cyc();
        mispredict = 1'b0;
        checks++;
        if (issued !== 1'b0) begin errors++; $display("FAIL head_flush_noissue: issued=%b required 0", issued); end
        cyc();
        checks++;
        if (issued !== 1'b0 || rs_full !== 1'b0) begin
            errors++; $display("FAIL head_flush_empty: issued=%b full=%b required 0/0", issued, rs_full);
        end
        fu_mem_ready = 1'b0;
        disp(5'd6, LW, 7'd13, 1'b1);
        disp(5'd8, LW, 7'd14, 1'b1);
        mispredict = 1'b1; mispredict_tag = 5'd7; curr_rob_tag = 5'd10; fu_mem_ready = 1'b1;
        cyc();
        mispredict = 1'b0;
        checks++;
        if (issued !== 1'b1 || data_out.rob_index !== 5'd6) begin
            errors++; $display("FAIL flush_with_issue: issued=%b rob=%0d required 1/6", issued, data_out.rob_index);
        end
        cyc();
        checks++;
        if (issued !== 1'b0) begin errors++; $display("FAIL flushed_tail_gone: issued=%b required 0", issued); end
    endtask

    task automatic test_stall();
        fu_mem_ready = 1'b0;
        disp(5'd3, LW, 7'd11, 1'b1);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (issued !== 1'b0) begin errors++; $display("FAIL stall_%0d: issued=%b required 0", i, issued); end
            if (i < 2) cyc();
        end
        fu_mem_ready = 1'b1;
        cyc();
        checks++;
        if (issued !== 1'b1 || data_out.rob_index !== 5'd3) begin
            errors++; $display("FAIL stall_release: issued=%b rob=%0d required 1/3", issued, data_out.rob_index);
        end
        cyc();
    endtask

    task automatic test_reset_mid();
        fu_mem_ready = 1'b0;
        disp(5'd20, LW, 7'd30, 1'b1);
        disp(5'd21, LW, 7'd31, 1'b1);
        disp(5'd22, LW, 7'd32, 1'b1);
        fu_mem_ready = 1'b1;
        cyc();
        checks++;
        if (issued !== 1'b1 || data_out.rob_index !== 5'd20) begin
            errors++; $display("FAIL pre_reset_issue: issued=%b rob=%0d required 1/20", issued, data_out.rob_index);
        end
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        checks++;
        if (issued !== 1'b0 || rs_full !== 1'b0 || data_out !== '0 || issue_ps1 !== '0) begin
            errors++;
            $display("FAIL mid_reset: issued=%b full=%b data=%h ps1=%0d required 0/0/0/0", issued, rs_full, data_out, issue_ps1);
        end
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++;
            if (issued !== 1'b0) begin errors++; $display("FAIL post_reset_%0d: issued=%b required 0", i, issued); end
        end
    endtask

    initial begin
        reset = 1'b1; dispatch_valid = 1'b0; dispatch_data = '0; dispatch_ps1 = '0; dispatch_ps1_rdy = 1'b0;
        cdb_valid = 1'b0; cdb_tag = '0; fu_mem_ready = 1'b0; mispredict = 1'b0;
        mispredict_tag = '0; curr_rob_tag = '0;
        @(negedge clk);
        test_reset();
        test_basic_issue();
        test_wakeup();
        test_full();
        test_flush_window();
        test_flush_head();
        test_stall();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
